// File: rtl/clas_pkg.sv
// Shared definitions for the serial add/subtract engine.
//   IDLE/RUN/DONE: sequencer state encodings
//   SLICE_W      : width of the shared arithmetic slice
//   GRP_W        : lookahead group width inside a slice
package clas_pkg;

    localparam int unsigned SLICE_W = 16;
    localparam int unsigned GRP_W   = 4;
    localparam int unsigned N_GRP   = SLICE_W / GRP_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/clas_16bit.sv
// 16-bit add/subtract slice with two-level carry lookahead (4-bit groups).
// Ports:
//   a, b     : slice operands
//   sel      : 0 = add, 1 = invert b (subtract when c_in = 1)
//   c_in     : carry into bit 0
//   sum_c    : combinational slice sum
//   c_out_c  : combinational carry out of bit 15
module clas_16bit
    import clas_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               sel,
    input  logic               c_in,
    output logic [SLICE_W-1:0] sum_c,
    output logic               c_out_c
);

    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [N_GRP:0]     cg;
    logic               gg;
    logic               pg;
    logic               c_bit;

    // Group generate/propagate give each nibble its carry-in directly;
    // bits inside a nibble ripple from that group carry.
    always_comb begin
        b_eff = sel ? ~b : b;
        g     = a & b_eff;
        p     = a ^ b_eff;
        cg    = '0;
        cg[0] = c_in;
        sum_c = '0;
        gg    = 1'b0;
        pg    = 1'b0;
        c_bit = 1'b0;
        for (int k = 0; k < int'(N_GRP); k++) begin
            gg = g[GRP_W*k+3]
               | (p[GRP_W*k+3] & g[GRP_W*k+2])
               | (p[GRP_W*k+3] & p[GRP_W*k+2] & g[GRP_W*k+1])
               | (p[GRP_W*k+3] & p[GRP_W*k+2] & p[GRP_W*k+1] & g[GRP_W*k]);
            pg = &p[GRP_W*k +: GRP_W];
            cg[k+1] = gg | (pg & cg[k]);
            c_bit = cg[k];
            for (int j = 0; j < int'(GRP_W); j++) begin
                sum_c[GRP_W*k+j] = p[GRP_W*k+j] ^ c_bit;
                c_bit = g[GRP_W*k+j] | (p[GRP_W*k+j] & c_bit);
            end
        end
        c_out_c = cg[N_GRP];
    end

endmodule

// File: rtl/clas_seq_64bit.sv
// Serial W-bit add/subtract built from one shared 16-bit slice, low slice first.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : request pulse, accepted only in IDLE
//   sel         : 0 = add, 1 = subtract (b inverted)
//   a, b, c_in  : operands and carry-in, sampled on accepted start
//   busy        : high while slices are computed
//   done        : one-cycle pulse when result/c_out/ovf are valid
//   result      : W-bit sum or difference
//   c_out       : carry out of the top slice
//   ovf         : signed overflow of the W-bit operation
module clas_seq_64bit
    import clas_pkg::*;
#(
    parameter int unsigned N_SLICE = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       sel,
    input  logic [SLICE_W*N_SLICE-1:0] a,
    input  logic [SLICE_W*N_SLICE-1:0] b,
    input  logic                       c_in,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*N_SLICE-1:0] result,
    output logic                       c_out,
    output logic                       ovf
);

    localparam int unsigned W     = SLICE_W * N_SLICE;
    localparam int unsigned IDX_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICE - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               sel_q;

    logic [SLICE_W-1:0] a_sl_c;
    logic [SLICE_W-1:0] b_sl_c;
    logic [SLICE_W-1:0] sum_c;
    logic               slice_co_c;
    logic               last_c;
    logic               top_beff_c;
    logic               ovf_c;

    // Slice-index operand mux
    always_comb begin
        a_sl_c = a_q[SLICE_W*32'(idx) +: SLICE_W];
        b_sl_c = b_q[SLICE_W*32'(idx) +: SLICE_W];
        last_c = (idx == LAST_IDX);
    end

    // Signed overflow, evaluated while the top slice is in the adder
    always_comb begin
        top_beff_c = sel_q ? ~b_q[W-1] : b_q[W-1];
        ovf_c      = (a_q[W-1] == top_beff_c) && (sum_c[SLICE_W-1] != a_q[W-1]);
    end

    clas_16bit u_slice (
        .a       (a_sl_c),
        .b       (b_sl_c),
        .sel     (sel_q),
        .c_in    (carry_q),
        .sum_c   (sum_c),
        .c_out_c (slice_co_c)
    );

    // Sequencer, operand capture and result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            result  <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sel_q   <= sel;
                        carry_q <= c_in;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result[SLICE_W*32'(idx) +: SLICE_W] <= sum_c;
                    carry_q <= slice_co_c;
                    idx     <= idx + IDX_W'(1);
                    if (last_c) begin
                        c_out <= slice_co_c;
                        ovf   <= ovf_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clas_seq_64bit.sv
// Scoreboard bench for clas_seq_64bit: directed vectors push expected
// responses; a monitor pops and compares on every done pulse.
module tb_clas_seq_64bit;

    localparam int unsigned N_SLICE = 4;
    localparam int unsigned W       = 16 * N_SLICE;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int unsigned  acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         ovf;

    exp_t        sb[$];
    int unsigned cyc      = 0;
    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    int unsigned done_cnt = 0;
    logic        prev_done = 1'b0;

    clas_seq_64bit #(.N_SLICE(N_SLICE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sel    (sel),
        .a      (a),
        .b      (b),
        .c_in   (c_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else if (done) begin
            exp_t e;
            done_cnt++;
            chk("done_single_pulse", W'(prev_done), W'(0));
            chk("busy_low_in_done", W'(busy), W'(0));
            if (sb.size() == 0) begin
                chk("unexpected_done", W'(1), W'(0));
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("c_out", W'(c_out), W'(e.co));
                chk("ovf", W'(ovf), W'(e.ov));
                // done is seen in the cycle after the N_SLICE-th edge past acceptance
                chk("latency", W'(cyc - e.acc), W'(N_SLICE));
            end
            prev_done = 1'b1;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", W'(1), W'(0));
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                          input logic ts, input logic tc,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        a = ta; b = tb_op; sel = ts; c_in = tc; start = 1'b1;
        @(posedge clk);
        #1;
        e.res = er; e.co = ec; e.ov = eo; e.acc = cyc;
        sb.push_back(e);
        start = 1'b0;
        // Scramble inputs after acceptance; the in-flight op must not see them
        a = ~ta; b = ~tb_op; sel = ~ts; c_in = ~tc;
        @(negedge clk);
        chk("busy_in_run", W'(busy), W'(1));
        wait_drain();
        repeat (2) @(negedge clk);
        chk("hold_result", result, er);
    endtask

    initial begin
        exp_t e;
        int unsigned dc;
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_c_out", W'(c_out), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        rst_n = 1'b1;

        run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        run_op(64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0);
        run_op(64'd5, 64'd3, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_op(64'h0, 64'h0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0);

        // start held high through RUN and DONE with different operands
        @(negedge clk);
        a = 64'h0000_FFFF_0000_FFFF; b = 64'h0000_0001_0000_0001; sel = 1'b0; c_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.res = 64'h0001_0000_0001_0000; e.co = 1'b0; e.ov = 1'b0; e.acc = cyc;
        sb.push_back(e);
        a = 64'd3; b = 64'd4;
        repeat (6) @(posedge clk);
        #1;
        e.res = 64'd7; e.co = 1'b0; e.ov = 1'b0; e.acc = cyc;
        sb.push_back(e);
        start = 1'b0;
        wait_drain();

        // Reset two edges into an operation aborts it with no done
        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sel = 1'b0; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_result", result, W'(0));
        chk("abort_c_out", W'(c_out), W'(0));
        chk("abort_ovf", W'(ovf), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", W'(done_cnt), W'(dc));

        run_op(64'd100, 64'd58, 1'b1, 1'b1, 64'd42, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", W'(sb.size()), W'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
